// File: rtl/keyboard_pkg.sv
// Shared constants, types and helpers for the PS/2 set-2 key event path.
// Prefix bytes, idle-state control bytes, decoder states and the event record.
package keyboard_pkg;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  // Bytes after the E1 that complete a pause sequence (8 bytes total).
  localparam int unsigned PAUSE_TAIL = 7;

  localparam int unsigned N_CTRL = 6;
  localparam logic [7:0] CTRL_BYTES [N_CTRL] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PFX,
    ST_PAUSE
  } dec_state_t;

  localparam int unsigned EVT_W = 10;

  typedef struct packed {
    logic       ext;
    logic       make;
    logic [7:0] code;
  } key_event_t;

  function automatic logic is_ctrl_byte(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_CTRL; i++) begin
      if (b == CTRL_BYTES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy level.
// The head is held in a register so the output is stable and holds its last value when empty.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [WIDTH-1:0] r_head;

  logic        w_pop;
  logic        w_push;
  logic [AW-1:0] w_rd_next;
  logic [AW:0] w_remain;
  logic [AW:0] w_level_next;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_level = r_level;
  assign o_data  = r_head;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves a latch.
  always_comb begin
    w_pop        = i_pop && !o_empty;
    w_push       = i_push && (!o_full || w_pop);
    w_rd_next    = r_rd_ptr + AW'(w_pop);
    w_remain     = r_level - (AW+1)'(w_pop);
    w_level_next = w_remain + (AW+1)'(w_push);
  end

  // NOTE: storage has no reset; validity is tracked by the level, so only control state is reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_next;
      r_level  <= w_level_next;
      // The next head is the incoming word only when nothing older remains.
      if (w_level_next != '0) begin
        r_head <= (w_remain == '0) ? i_data : r_mem[w_rd_next];
      end
    end
  end

endmodule

// File: rtl/keycode_event_queue.sv
// PS/2 set-2 scan-byte decoder with typematic repeat filter and an event FIFO.
// Prefix/pause sequences are collapsed into {ext, make, code} events for the consumer.
module keycode_event_queue
  import keyboard_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int REPEAT_FILTER = 1,
  parameter int PAUSE_EN      = 1,
  parameter int FILTER_CTRL   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_key_en,
  input  logic [7:0]                    ps2_key_data,
  output logic [7:0]                    event_code,
  output logic                          event_ext,
  output logic                          event_make,
  output logic                          event_valid,
  input  logic                          event_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  dec_state_t r_state;
  dec_state_t w_state_next;
  logic       r_ext;
  logic       r_brk;
  logic       w_ext_next;
  logic       w_brk_next;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_next;

  logic       w_complete;
  logic       w_is_pause;
  key_event_t w_evt;
  logic       w_drop;
  logic       w_push;
  logic       w_pop_req;
  logic       r_overflow;

  key_event_t w_head;
  logic       w_empty;
  logic       w_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      r_state <= w_state_next;
      r_ext   <= w_ext_next;
      r_brk   <= w_brk_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ext_next   = r_ext;
    w_brk_next   = r_brk;
    w_cnt_next   = r_cnt;
    w_complete   = 1'b0;
    w_is_pause   = 1'b0;
    w_evt        = '0;
    if (ps2_key_en) begin
      unique case (r_state)
        ST_IDLE: begin
          if (ps2_key_data == PFX_EXT) begin
            w_ext_next   = 1'b1;
            w_state_next = ST_PFX;
          end else if (ps2_key_data == PFX_BRK) begin
            w_brk_next   = 1'b1;
            w_state_next = ST_PFX;
          end else if (ps2_key_data == PFX_PAUSE && PAUSE_EN != 0) begin
            w_cnt_next   = 3'(PAUSE_TAIL);
            w_state_next = ST_PAUSE;
          end else if (FILTER_CTRL != 0 && is_ctrl_byte(ps2_key_data)) begin
            w_state_next = ST_IDLE;
          end else begin
            w_complete = 1'b1;
            w_evt      = '{ext: 1'b0, make: 1'b1, code: ps2_key_data};
          end
        end
        ST_PFX: begin
          if (ps2_key_data == PFX_BRK) begin
            w_brk_next = 1'b1;
          end else if (ps2_key_data == PFX_EXT) begin
            w_ext_next = 1'b1;
          end else begin
            w_complete   = 1'b1;
            w_evt        = '{ext: r_ext, make: ~r_brk, code: ps2_key_data};
            w_ext_next   = 1'b0;
            w_brk_next   = 1'b0;
            w_state_next = ST_IDLE;
          end
        end
        ST_PAUSE: begin
          w_cnt_next = r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            w_complete   = 1'b1;
            w_is_pause   = 1'b1;
            w_evt        = '{ext: 1'b1, make: 1'b1, code: PFX_PAUSE};
            w_state_next = ST_IDLE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Key-state map indexed {ext, code}; updated even when the FIFO drops the event.
  if (REPEAT_FILTER != 0) begin : g_filter
    logic [511:0] r_held;
    logic [8:0]   w_idx;

    assign w_idx  = {w_evt.ext, w_evt.code};
    assign w_drop = w_evt.make && r_held[w_idx] && !w_is_pause;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_held <= '0;
      end else if (w_complete && !w_is_pause) begin
        r_held[w_idx] <= w_evt.make;
      end
    end
  end else begin : g_no_filter
    assign w_drop = 1'b0;
  end

  assign w_push    = w_complete && !w_drop;
  assign w_pop_req = event_valid && event_ready;

  sync_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_evt),
    .i_pop   (event_ready),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) r_overflow <= 1'b0;
    else       r_overflow <= w_push && w_full && !w_pop_req;
  end

  assign event_valid = !w_empty;
  assign event_code  = w_head.code;
  assign event_ext   = w_head.ext;
  assign event_make  = w_head.make;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Bench for keycode_event_queue: two configurations driven by one byte stream, each checked
// every cycle against a sequence-based reference model, plus literal directed expectations.
module tb_keycode_event_queue;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_key_en = 1'b0;
  logic [7:0] ps2_key_data = 8'h00;
  logic       event_ready = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_ctrl(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  // Instance 0: depth 4, filters on. Instance 1: depth 8, filters off.
  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int D  = (g == 0) ? 4 : 8;
    localparam int ON = (g == 0) ? 1 : 0;
    localparam int LW = $clog2(D) + 1;

    logic [7:0]    code;
    logic          ext, make, valid, ovf;
    logic [LW-1:0] level;

    keycode_event_queue #(
      .FIFO_DEPTH    (D),
      .REPEAT_FILTER (ON),
      .PAUSE_EN      (ON),
      .FILTER_CTRL   (ON)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .ps2_key_en   (ps2_key_en),
      .ps2_key_data (ps2_key_data),
      .event_code   (code),
      .event_ext    (ext),
      .event_make   (make),
      .event_valid  (valid),
      .event_ready  (event_ready),
      .fifo_level   (level),
      .overflow     (ovf)
    );

    // Model: bytes of the current sequence, expected queue {ext, make, code}, held keys.
    logic [7:0] seq [$];
    logic [9:0] q [$];
    bit         held [512];
    bit         exp_ovf = 1'b0;
    int         ovf_seen = 0;

    always @(posedge clk) begin : model
      logic [9:0] ev;
      logic [8:0] idx;
      bit         have, is_pause, pop, has_e0, has_f0;
      if (reset) begin
        q.delete();
        seq.delete();
        foreach (held[i]) held[i] = 1'b0;
        exp_ovf = 1'b0;
      end else begin
        have     = 1'b0;
        is_pause = 1'b0;
        ev       = '0;
        pop      = (q.size() != 0) && event_ready;
        if (ps2_key_en) begin
          seq.push_back(ps2_key_data);
          if (ON != 0 && seq[0] == 8'hE1) begin
            if (seq.size() == 8) begin
              have = 1'b1; is_pause = 1'b1; ev = {1'b1, 1'b1, 8'hE1};
              seq.delete();
            end
          end else if (seq.size() == 1 && ON != 0 && is_ctrl(seq[0])) begin
            seq.delete();
          end else if (ps2_key_data != 8'hE0 && ps2_key_data != 8'hF0) begin
            has_e0 = 1'b0; has_f0 = 1'b0;
            foreach (seq[i]) begin
              if (seq[i] == 8'hE0) has_e0 = 1'b1;
              if (seq[i] == 8'hF0) has_f0 = 1'b1;
            end
            have = 1'b1;
            ev   = {has_e0, !has_f0, ps2_key_data};
            seq.delete();
          end
        end
        if (have && ON != 0 && !is_pause) begin
          idx = {ev[9], ev[7:0]};
          if (ev[8] && held[idx]) have = 1'b0;
          held[idx] = ev[8];
        end
        if (pop) void'(q.pop_front());
        exp_ovf = 1'b0;
        if (have) begin
          if (q.size() < D) q.push_back(ev);
          else exp_ovf = 1'b1;
        end
      end
      #1;
      check($sformatf("dut%0d valid", g), valid, q.size() != 0);
      check($sformatf("dut%0d level", g), level, q.size());
      check($sformatf("dut%0d overflow", g), ovf, exp_ovf);
      if (q.size() != 0) check($sformatf("dut%0d head", g), {ext, make, code}, q[0]);
      if (ovf) ovf_seen++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ps2_key_en   = 1'b1;
    ps2_key_data = b;
    @(negedge clk);
    ps2_key_en   = 1'b0;
  endtask

  // Bytes packed first-in at the most significant end.
  task automatic send_seq(input int n, input logic [63:0] bytes);
    for (int i = 0; i < n; i++) send_byte(bytes[8*(n-1-i) +: 8]);
  endtask

  task automatic drain();
    int k;
    @(negedge clk);
    event_ready = 1'b1;
    k = 0;
    while ((g_inst[0].valid || g_inst[1].valid) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("drain empty", {g_inst[0].valid, g_inst[1].valid}, 2'b00);
    event_ready = 1'b0;
  endtask

  initial begin
    int base;
    logic [7:0] codes [8];
    int r;
    codes = '{8'h1C, 8'h1D, 8'h75, 8'h14, 8'h77, 8'h6B, 8'h5A, 8'h29};

    repeat (3) @(negedge clk);
    check("rst valid0", g_inst[0].valid, 0);
    check("rst level0", g_inst[0].level, 0);
    check("rst ovf0", g_inst[0].ovf, 0);
    check("rst head0", {g_inst[0].ext, g_inst[0].make, g_inst[0].code}, 0);
    check("rst head1", {g_inst[1].ext, g_inst[1].make, g_inst[1].code}, 0);
    reset = 1'b0;

    // Plain make, visible right after the strobe edge.
    @(negedge clk);
    ps2_key_en = 1'b1;
    ps2_key_data = 8'h1C;
    check("pre-edge valid0", g_inst[0].valid, 0);
    @(posedge clk);
    #1;
    check("make valid0", g_inst[0].valid, 1);
    check("make head0", {g_inst[0].ext, g_inst[0].make, g_inst[0].code}, {2'b01, 8'h1C});
    @(negedge clk);
    ps2_key_en = 1'b0;
    drain();

    send_seq(2, {8'hF0, 8'h1C});
    check("break head0", {g_inst[0].ext, g_inst[0].make, g_inst[0].code}, {2'b00, 8'h1C});
    drain();

    send_seq(3, {8'hE0, 8'hF0, 8'h75});
    check("ext break head0", {g_inst[0].ext, g_inst[0].make, g_inst[0].code}, {2'b10, 8'h75});
    drain();

    send_seq(5, {8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C});
    check("repeat filt level0", g_inst[0].level, 2);
    check("repeat nofilt level1", g_inst[1].level, 4);
    drain();

    send_seq(8, 64'hE1_14_77_E1_F0_14_F0_77);
    check("pause level0", g_inst[0].level, 1);
    check("pause head0", {g_inst[0].ext, g_inst[0].make, g_inst[0].code}, {2'b11, 8'hE1});
    check("no-pause level1", g_inst[1].level, 6);
    send_byte(8'h1C);
    check("after pause level0", g_inst[0].level, 2);
    check("after pause level1", g_inst[1].level, 7);
    drain();

    base = g_inst[0].ovf_seen;
    send_seq(6, {16'h0, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35});
    check("full level0", g_inst[0].level, 4);
    check("overflow pulses0", g_inst[0].ovf_seen - base, 2);
    check("full head0", {g_inst[0].ext, g_inst[0].make, g_inst[0].code}, {2'b01, 8'h15});
    check("no overflow level1", g_inst[1].level, 6);
    @(negedge clk);
    ps2_key_en = 1'b1;
    ps2_key_data = 8'h3C;
    event_ready = 1'b1;
    @(posedge clk);
    #1;
    check("full push+pop level0", g_inst[0].level, 4);
    check("full push+pop ovf0", g_inst[0].ovf, 0);
    check("full push+pop head0", {g_inst[0].ext, g_inst[0].make, g_inst[0].code}, {2'b01, 8'h1D});
    @(negedge clk);
    ps2_key_en = 1'b0;
    event_ready = 1'b0;
    drain();

    send_byte(8'hE0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h1C);
    check("reset mid-seq level0", g_inst[0].level, 1);
    check("reset mid-seq head0", {g_inst[0].ext, g_inst[0].make, g_inst[0].code}, {2'b01, 8'h1C});
    drain();

    send_seq(2, {8'hAA, 8'hFA});
    check("ctrl filtered level0", g_inst[0].level, 0);
    check("ctrl passed level1", g_inst[1].level, 2);
    drain();

    // Randomised traffic: low-ready phase then high-ready phase, occasional reset.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      r = $urandom_range(0, 15);
      ps2_key_en = ($urandom_range(0, 2) == 0);
      case (r)
        0:       ps2_key_data = 8'hE0;
        1, 2:    ps2_key_data = 8'hF0;
        3:       ps2_key_data = 8'hE1;
        4:       ps2_key_data = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFA;
        default: ps2_key_data = codes[$urandom_range(0, 7)];
      endcase
      event_ready = (i < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    ps2_key_en = 1'b0;
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
